// File: rtl/imem_loader.sv
// rtl/imem_loader.sv - boot loader: byte stream -> little-endian words into instruction memory,
// holding the core in reset until the image and its checksum are accepted.
module imem_loader #(
  parameter logic [31:0] BASE_ADDR   = 32'h0000_3000,
  parameter int          DEPTH_WORDS = 1024
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  in_data,
  input  logic        in_valid,
  output logic        in_ready,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wd,
  output logic        cpu_reset,
  output logic        done,
  output logic        error,
  output logic [15:0] words_written
);

  typedef enum logic [2:0] {
    S_LEN_LO,
    S_LEN_HI,
    S_DATA,
    S_CHECK,
    S_DONE,
    S_ERROR
  } state_t;

  localparam logic [31:0] DEPTH = 32'(DEPTH_WORDS);

  state_t      state;
  logic [7:0]  len_lo;
  logic [15:0] len;
  logic [1:0]  lane;
  logic [23:0] word_buf;
  logic [7:0]  sum;
  logic        xfer;
  logic [15:0] n_rx;

  assign in_ready = !reset && (state == S_LEN_LO || state == S_LEN_HI ||
                               state == S_DATA   || state == S_CHECK);
  assign xfer     = in_valid && in_ready;
  assign n_rx     = {in_data, len_lo};

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= S_LEN_LO;
      len_lo        <= 8'd0;
      len           <= 16'd0;
      lane          <= 2'd0;
      word_buf      <= 24'd0;
      sum           <= 8'd0;
      mem_we        <= 1'b0;
      mem_addr      <= BASE_ADDR;
      mem_wd        <= 32'd0;
      cpu_reset     <= 1'b1;
      done          <= 1'b0;
      error         <= 1'b0;
      words_written <= 16'd0;
    end else begin
      mem_we <= 1'b0;
      case (state)
        S_LEN_LO: begin
          if (xfer) begin
            len_lo <= in_data;
            state  <= S_LEN_HI;
          end
        end
        S_LEN_HI: begin
          if (xfer) begin
            len <= n_rx;
            if ({16'd0, n_rx} > DEPTH) begin
              state <= S_ERROR;
              error <= 1'b1;
            end else if (n_rx == 16'd0) begin
              state <= S_CHECK;
            end else begin
              state <= S_DATA;
            end
          end
        end
        S_DATA: begin
          if (xfer) begin
            sum  <= sum + in_data;
            lane <= lane + 2'd1;
            case (lane)
              2'd0: word_buf[7:0]   <= in_data;
              2'd1: word_buf[15:8]  <= in_data;
              2'd2: word_buf[23:16] <= in_data;
              default: begin
                // words_written still equals this word's index: the previous
                // word's write landed at least three cycles ago.
                mem_wd        <= {in_data, word_buf};
                mem_addr      <= BASE_ADDR + {14'd0, words_written, 2'b00};
                mem_we        <= 1'b1;
                words_written <= words_written + 16'd1;
                if (words_written + 16'd1 == len) state <= S_CHECK;
              end
            endcase
          end
        end
        S_CHECK: begin
          if (xfer) begin
            if (in_data == sum) begin
              state     <= S_DONE;
              done      <= 1'b1;
              cpu_reset <= 1'b0;
            end else begin
              state <= S_ERROR;
              error <= 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// tb/tb_imem_loader.sv - table-driven frames plus hand sequences for mid-frame reset
// and a full-depth image.
module tb_imem_loader;

  localparam logic [31:0] BASE = 32'h0000_3000;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [7:0]  in_data = 8'd0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wd;
  logic        cpu_reset;
  logic        done;
  logic        error;
  logic [15:0] words_written;

  imem_loader dut (
    .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wd(mem_wd),
    .cpu_reset(cpu_reset), .done(done), .error(error), .words_written(words_written)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [95:0] bytes;     // byte i at [95-8*i -: 8]
    int          nbytes;
    bit          gapped;
    int          exp_xfers;
    int          exp_writes;
    logic [31:0] d0;
    logic [31:0] d1;
    bit          exp_done;
    bit          exp_err;
    int          term_idx;
  } vec_t;

  int n_vec = 0;
  int n_bad = 0;
  int cyc = 0;
  int term_cyc = -1;
  int xfer_q[$];
  int wr_cyc[$];
  logic [31:0] wr_addr[$];
  logic [31:0] wr_data[$];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (in_valid && in_ready) xfer_q.push_back(cyc);
    if (mem_we) begin
      wr_cyc.push_back(cyc);
      wr_addr.push_back(mem_addr);
      wr_data.push_back(mem_wd);
    end
    if ((done || error) && term_cyc < 0) term_cyc = cyc;
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic clear_logs();
    xfer_q.delete();
    wr_cyc.delete();
    wr_addr.delete();
    wr_data.delete();
    term_cyc = -1;
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset(input string tag);
    reset = 1'b1;
    in_valid = 1'b0;
    tick(2);
    check({tag, " rst in_ready"}, 32'(in_ready), 32'd0);
    check({tag, " rst mem_we"}, 32'(mem_we), 32'd0);
    check({tag, " rst mem_addr"}, mem_addr, BASE);
    check({tag, " rst mem_wd"}, mem_wd, 32'd0);
    check({tag, " rst cpu_reset/done/error"}, {29'd0, cpu_reset, done, error}, 32'b100);
    check({tag, " rst words_written"}, 32'(words_written), 32'd0);
    reset = 1'b0;
    clear_logs();
    #1;
    check({tag, " in_ready after reset"}, 32'(in_ready), 32'd1);
  endtask

  task automatic send_byte(input logic [7:0] b, input bit gapped);
    if (gapped) begin
      in_valid = 1'b0;
      tick($urandom_range(0, 2));
    end
    in_valid = 1'b1;
    in_data  = b;
    tick(1);
    in_valid = 1'b0;
  endtask

  vec_t vecs[6];

  initial begin
    vecs[0] = '{96'h02_00_13_05_00_00_93_05_10_00_C0_00, 11, 0, 11, 2,
                32'h0000_0513, 32'h0010_0593, 1, 0, 10};
    vecs[1] = '{96'h02_00_13_05_00_00_93_05_10_00_C1_55, 12, 0, 11, 2,
                32'h0000_0513, 32'h0010_0593, 0, 1, 10};
    vecs[2] = '{96'h00_00_00_00_00_00_00_00_00_00_00_00, 3, 0, 3, 0,
                32'h0, 32'h0, 1, 0, 2};
    vecs[3] = '{96'h01_04_11_22_00_00_00_00_00_00_00_00, 4, 0, 2, 0,
                32'h0, 32'h0, 0, 1, 1};
    vecs[4] = '{96'h02_00_13_05_00_00_93_05_10_00_C0_00, 11, 1, 11, 2,
                32'h0000_0513, 32'h0010_0593, 1, 0, 10};
    vecs[5] = '{96'h01_00_AA_BB_CC_DD_0E_00_00_00_00_00, 7, 0, 7, 1,
                32'hDDCC_BBAA, 32'h0, 1, 0, 6};

    for (int v = 0; v < 6; v++) begin
      string tag;
      int    idx;
      tag = $sformatf("v%0d", v);
      do_reset(tag);
      for (int i = 0; i < vecs[v].nbytes; i++)
        send_byte(vecs[v].bytes[95-8*i -: 8], vecs[v].gapped);
      tick(3);
      check({tag, " xfers"}, 32'(xfer_q.size()), 32'(vecs[v].exp_xfers));
      check({tag, " writes"}, 32'(wr_cyc.size()), 32'(vecs[v].exp_writes));
      for (int j = 0; j < wr_cyc.size() && j < 2; j++) begin
        check($sformatf("%s w%0d addr", tag, j), wr_addr[j], BASE + 32'(4 * j));
        check($sformatf("%s w%0d data", tag, j), wr_data[j], (j == 0) ? vecs[v].d0 : vecs[v].d1);
        idx = 2 + 4 * j + 3;
        check($sformatf("%s w%0d latency", tag, j), 32'(wr_cyc[j]),
              (idx < xfer_q.size()) ? 32'(xfer_q[idx] + 1) : 32'hFFFF_FFFF);
      end
      check({tag, " words_written"}, 32'(words_written), 32'(vecs[v].exp_writes));
      check({tag, " done"}, 32'(done), 32'(vecs[v].exp_done));
      check({tag, " error"}, 32'(error), 32'(vecs[v].exp_err));
      check({tag, " cpu_reset"}, 32'(cpu_reset), 32'(!vecs[v].exp_done));
      check({tag, " in_ready terminal"}, 32'(in_ready), 32'd0);
      check({tag, " term timing"}, 32'(term_cyc),
            (vecs[v].term_idx < xfer_q.size()) ? 32'(xfer_q[vecs[v].term_idx] + 1) : 32'hFFFF_FFFF);
    end

    // Reset after 6 payload bytes, with a byte offered during reset, then a fresh frame.
    begin
      logic [63:0] part;
      logic [55:0] fresh;
      part  = 64'h02_00_13_05_00_00_93_05;
      fresh = 56'h01_00_AA_BB_CC_DD_0E;
      do_reset("mid");
      for (int i = 0; i < 8; i++) send_byte(part[63-8*i -: 8], 1'b0);
      clear_logs();
      reset    = 1'b1;
      in_valid = 1'b1;
      in_data  = 8'h10;
      tick(1);
      check("mid reset words_written", 32'(words_written), 32'd0);
      check("mid reset mem_addr", mem_addr, BASE);
      reset    = 1'b0;
      in_valid = 1'b0;
      for (int i = 0; i < 7; i++) send_byte(fresh[55-8*i -: 8], 1'b0);
      tick(3);
      check("mid writes", 32'(wr_cyc.size()), 32'd1);
      if (wr_cyc.size() > 0) begin
        check("mid w0 addr", wr_addr[0], BASE);
        check("mid w0 data", wr_data[0], 32'hDDCC_BBAA);
      end
      check("mid words_written", 32'(words_written), 32'd1);
      check("mid done", 32'(done), 32'd1);
    end

    // Full-depth image: N == DEPTH_WORDS is legal and the last address is BASE+4*1023.
    begin
      logic [7:0]  csum;
      logic [31:0] w;
      int          bad_addr;
      int          bad_data;
      csum = 8'd0;
      bad_addr = 0;
      bad_data = 0;
      do_reset("full");
      send_byte(8'h00, 1'b0);
      send_byte(8'h04, 1'b0);
      for (int k = 0; k < 1024; k++) begin
        w = 32'(k) * 32'h0001_0203 + 32'h5A;
        for (int b = 0; b < 4; b++) begin
          send_byte(w[8*b +: 8], 1'b0);
          csum = csum + w[8*b +: 8];
        end
      end
      send_byte(csum, 1'b0);
      tick(3);
      check("full writes", 32'(wr_cyc.size()), 32'd1024);
      for (int k = 0; k < wr_cyc.size(); k++) begin
        w = 32'(k) * 32'h0001_0203 + 32'h5A;
        if (wr_addr[k] !== BASE + 32'(4 * k)) bad_addr++;
        if (wr_data[k] !== w) bad_data++;
      end
      check("full bad addrs", 32'(bad_addr), 32'd0);
      check("full bad data", 32'(bad_data), 32'd0);
      check("full last addr", mem_addr, 32'h0000_3FFC);
      check("full words_written", 32'(words_written), 32'd1024);
      check("full done/error", {30'd0, done, error}, 32'b10);
      check("full cpu_reset", 32'(cpu_reset), 32'd0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
